pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer_pkg.sv | 12 +
 rtl/pc_target_calc.sv | 40 ++++
 rtl/pc_sequencer.sv | 83 ++++++++
 tb/tb_pc_sequencer.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared state encoding and reset constant for the PC sequencer.
// Optional feature macro: PC_ALIGN_CHECK_EN (jumpR target alignment check).
package pc_sequencer_pkg;

    typedef enum logic {
        FETCH = 1'b0,
        EXEC  = 1'b1
    } state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;

endpackage

// File: rtl/pc_target_calc.sv
// Combinational next-PC selection: jumpR > jump > pcsrc > pc+4.
// With PC_ALIGN_CHECK_EN defined, jumpR targets are word-aligned and flagged.
module pc_target_calc (
    input  logic [31:0] pc,
    input  logic        pcsrc,
    input  logic        jump,
    input  logic        jumpR,
    input  logic [15:0] instr_imm,
    input  logic [25:0] instr_target,
    input  logic [31:0] reg_rs,
    output logic [31:0] next_pc,
    output logic        misaligned
);

    logic [31:0] pc4;
    logic [31:0] br_off;
    logic [31:0] rs_tgt;

    assign pc4    = pc + 32'd4;
    assign br_off = {{14{instr_imm[15]}}, instr_imm, 2'b00};

`ifdef PC_ALIGN_CHECK_EN
    assign misaligned = jumpR && (reg_rs[1:0] != 2'b00);
    assign rs_tgt     = {reg_rs[31:2], 2'b00};
`else
    assign misaligned = 1'b0;
    assign rs_tgt     = reg_rs;
`endif

    always_comb begin
        next_pc = pc4;
        if (jumpR)
            next_pc = rs_tgt;
        else if (jump)
            next_pc = {pc4[31:28], instr_target, 2'b00};
        else if (pcsrc)
            next_pc = pc4 + br_off;
    end

endmodule

// File: rtl/pc_sequencer.sv
// Two-state fetch/execute PC sequencer with link strobe and retire counter.
// Optional feature macro: PC_ALIGN_CHECK_EN (sticky misaligned-jumpR flag).
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_ready,
    input  logic        stall,
    input  logic        pcsrc,
    input  logic        jump,
    input  logic        jal,
    input  logic        jumpR,
    input  logic [15:0] instr_imm,
    input  logic [25:0] instr_target,
    input  logic [31:0] reg_rs,
    output logic [31:0] pc,
    output logic        fetch_req,
    output logic        link_we,
    output logic [31:0] link_addr,
    output logic [31:0] retired,
    output logic        align_err
);

    state_t      state;
    logic [31:0] next_pc;
    logic        misaligned;
    logic        advance;

    pc_target_calc u_calc (
        .pc           (pc),
        .pcsrc        (pcsrc),
        .jump         (jump),
        .jumpR        (jumpR),
        .instr_imm    (instr_imm),
        .instr_target (instr_target),
        .reg_rs       (reg_rs),
        .next_pc      (next_pc),
        .misaligned   (misaligned)
    );

    // An instruction completes on any non-stalled EXEC cycle.
    assign advance   = (state == EXEC) && !stall;
    assign fetch_req = (state == FETCH);
    assign link_we   = advance && jal;
    assign link_addr = pc + 32'd4;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= FETCH;
            pc      <= RESET_PC;
            retired <= 32'd0;
        end else begin
            unique case (state)
                FETCH: begin
                    if (instr_ready)
                        state <= EXEC;
                end
                EXEC: begin
                    if (!stall) begin
                        pc      <= next_pc;
                        retired <= retired + 32'd1;
                        state   <= FETCH;
                    end
                end
            endcase
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            align_err <= 1'b0;
        else if (advance && misaligned)
            align_err <= 1'b1;
    end
`else
    assign align_err = misaligned;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed table, reset/wrap
// sequences and randomized traffic against a behavioural model.
module tb_pc_sequencer;

    localparam logic [31:0] RPC = 32'h0040_0000;
`ifdef PC_ALIGN_CHECK_EN
    localparam bit ALN = 1'b1;
`else
    localparam bit ALN = 1'b0;
`endif

    typedef struct {
        bit          ready, stall, pcsrc, jump, jal, jumpr;
        logic [15:0] imm;
        logic [25:0] target;
        logic [31:0] rs;
    } in_t;

    typedef struct {
        in_t         i;
        bit          exp_fetch, exp_link, exp_err;
        logic [31:0] exp_pc, exp_ret;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_ready, stall, pcsrc, jump, jal, jumpR;
    logic [15:0] instr_imm;
    logic [25:0] instr_target;
    logic [31:0] reg_rs;
    logic [31:0] pc, link_addr, retired;
    logic        fetch_req, link_we, align_err;

    int passed = 0;
    int total  = 0;

    bit          m_exec;
    logic [31:0] m_pc, m_ret;
    bit          m_err;

    vec_t tbl[$];

    pc_sequencer #(.RESET_PC(RPC)) dut (
        .clk          (clk),
        .reset        (reset),
        .instr_ready  (instr_ready),
        .stall        (stall),
        .pcsrc        (pcsrc),
        .jump         (jump),
        .jal          (jal),
        .jumpR        (jumpR),
        .instr_imm    (instr_imm),
        .instr_target (instr_target),
        .reg_rs       (reg_rs),
        .pc           (pc),
        .fetch_req    (fetch_req),
        .link_we      (link_we),
        .link_addr    (link_addr),
        .retired      (retired),
        .align_err    (align_err)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp)
            passed++;
        else
            $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic in_t mk(bit r, bit s, bit ps, bit j, bit jl, bit jr,
                               logic [15:0] imm, logic [25:0] tg,
                               logic [31:0] rs);
        in_t x;
        x.ready = r; x.stall = s; x.pcsrc = ps; x.jump = j;
        x.jal = jl; x.jumpr = jr; x.imm = imm; x.target = tg; x.rs = rs;
        return x;
    endfunction

    function automatic vec_t v(in_t x, bit ef, bit el, logic [31:0] ep,
                               logic [31:0] er, bit ee);
        vec_t t;
        t.i = x; t.exp_fetch = ef; t.exp_link = el;
        t.exp_pc = ep; t.exp_ret = er; t.exp_err = ee;
        return t;
    endfunction

    task automatic apply(in_t x);
        instr_ready = x.ready; stall = x.stall; pcsrc = x.pcsrc;
        jump = x.jump; jal = x.jal; jumpR = x.jumpr;
        instr_imm = x.imm; instr_target = x.target; reg_rs = x.rs;
    endtask

    // Reference next-PC from the architectural rules.
    function automatic logic [31:0] ref_next(logic [31:0] cur, in_t x,
                                             output bit bad);
        logic [31:0] pc4;
        int          simm;
        bad  = 1'b0;
        pc4  = cur + 32'd4;
        simm = $signed(x.imm);
        if (x.jumpr) begin
            if (ALN && (x.rs % 4 != 0)) begin
                bad = 1'b1;
                return x.rs - (x.rs % 4);
            end
            return x.rs;
        end
        if (x.jump)
            return (pc4 & 32'hF000_0000) | ({6'd0, x.target} * 32'd4);
        if (x.pcsrc)
            return pc4 + 32'(simm * 4);
        return pc4;
    endfunction

    task automatic mstep(in_t x, string tag);
        bit          bad;
        logic [31:0] nxt;
        apply(x);
        @(negedge clk);
        chk({tag, " fetch_req"}, {31'd0, fetch_req}, {31'd0, !m_exec});
        chk({tag, " link_we"}, {31'd0, link_we},
            {31'd0, m_exec && !x.stall && x.jal});
        chk({tag, " link_addr"}, link_addr, m_pc + 32'd4);
        if (!m_exec) begin
            if (x.ready) m_exec = 1'b1;
        end else if (!x.stall) begin
            nxt = ref_next(m_pc, x, bad);
            if (bad) m_err = 1'b1;
            m_pc   = nxt;
            m_ret  = m_ret + 32'd1;
            m_exec = 1'b0;
        end
        @(posedge clk);
        #1;
        chk({tag, " pc"}, pc, m_pc);
        chk({tag, " retired"}, retired, m_ret);
        chk({tag, " align_err"}, {31'd0, align_err}, {31'd0, m_err});
    endtask

    task automatic model_reset();
        m_exec = 1'b0; m_pc = RPC; m_ret = 32'd0; m_err = 1'b0;
    endtask

    task automatic do_reset();
        apply(mk(0, 0, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0));
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic check_reset_state(string tag);
        chk({tag, " pc"}, pc, RPC);
        chk({tag, " retired"}, retired, 32'd0);
        chk({tag, " link_we"}, {31'd0, link_we}, 32'd0);
        chk({tag, " fetch_req"}, {31'd0, fetch_req}, 32'd1);
        chk({tag, " align_err"}, {31'd0, align_err}, 32'd0);
    endtask

    // Reset asserted asynchronously between edges, held across one edge.
    task automatic mid_reset(in_t x, string tag);
        apply(x);
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        check_reset_state({tag, " async"});
        @(posedge clk);
        #1;
        check_reset_state({tag, " held"});
        reset = 1'b0;
        model_reset();
    endtask

    logic [31:0] prev_pc;
    logic [31:0] aln_pc;
    in_t         rx;

    initial begin
        reset = 1'b1;
        apply(mk(0, 0, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0));
        #1;
        check_reset_state("reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_reset_state("post_reset");

        aln_pc = ALN ? 32'h0040_0200 : 32'h0040_0203;
        tbl.push_back(v(mk(1,0,0,0,0,0,16'h0,26'h0,32'h0), 1,0,32'h0040_0000, 0,0));
        tbl.push_back(v(mk(1,0,0,0,0,0,16'h0,26'h0,32'h0), 0,0,32'h0040_0004, 1,0));
        tbl.push_back(v(mk(1,0,0,0,0,0,16'h0,26'h0,32'h0), 1,0,32'h0040_0004, 1,0));
        tbl.push_back(v(mk(1,0,0,0,0,0,16'h0,26'h0,32'h0), 0,0,32'h0040_0008, 2,0));
        tbl.push_back(v(mk(1,0,0,0,0,0,16'h0,26'h0,32'h0), 1,0,32'h0040_0008, 2,0));
        tbl.push_back(v(mk(1,0,0,0,0,0,16'h0,26'h0,32'h0), 0,0,32'h0040_000C, 3,0));
        tbl.push_back(v(mk(1,0,0,0,0,0,16'h0,26'h0,32'h0), 1,0,32'h0040_000C, 3,0));
        tbl.push_back(v(mk(1,0,0,0,0,0,16'h0,26'h0,32'h0), 0,0,32'h0040_0010, 4,0));
        tbl.push_back(v(mk(1,0,1,0,1,0,16'hFFFC,26'h0,32'h0), 1,0,32'h0040_0010, 4,0));
        tbl.push_back(v(mk(1,0,1,0,0,0,16'hFFFC,26'h0,32'h0), 0,0,32'h0040_0004, 5,0));
        tbl.push_back(v(mk(1,0,0,0,0,0,16'h0,26'h0,32'h0), 1,0,32'h0040_0004, 5,0));
        tbl.push_back(v(mk(0,0,1,1,0,0,16'h0010,26'h0100008,32'h0), 0,0,32'h0040_0020, 6,0));
        tbl.push_back(v(mk(1,0,0,0,0,0,16'h0,26'h0,32'h0), 1,0,32'h0040_0020, 6,0));
        tbl.push_back(v(mk(1,0,0,1,1,0,16'h0,26'h0100040,32'h0), 0,1,32'h0040_0100, 7,0));
        tbl.push_back(v(mk(1,0,0,0,1,0,16'h0,26'h0,32'h0), 1,0,32'h0040_0100, 7,0));
        tbl.push_back(v(mk(1,1,0,1,1,1,16'h0,26'h0,32'h0040_0200), 0,0,32'h0040_0100, 7,0));
        tbl.push_back(v(mk(1,1,0,1,1,1,16'h0,26'h0,32'h0040_0200), 0,0,32'h0040_0100, 7,0));
        tbl.push_back(v(mk(1,1,0,1,1,1,16'h0,26'h0,32'h0040_0200), 0,0,32'h0040_0100, 7,0));
        tbl.push_back(v(mk(1,0,0,1,0,1,16'h0,26'h0,32'h0040_0200), 0,0,32'h0040_0200, 8,0));
        tbl.push_back(v(mk(0,0,0,0,0,1,16'h0,26'h0,32'h0040_0203), 1,0,32'h0040_0200, 8,0));
        tbl.push_back(v(mk(1,1,0,0,0,1,16'h0,26'h0,32'h0040_0203), 1,0,32'h0040_0200, 8,0));
        tbl.push_back(v(mk(1,0,0,0,0,1,16'h0,26'h0,32'h0040_0203), 0,0,aln_pc, 9,ALN));
        tbl.push_back(v(mk(1,0,0,0,0,0,16'h0,26'h0,32'h0), 1,0,aln_pc, 9,ALN));
        tbl.push_back(v(mk(1,0,0,0,0,0,16'h0,26'h0,32'h0), 0,0,aln_pc + 32'd4, 10,ALN));

        prev_pc = RPC;
        for (int k = 0; k < tbl.size(); k++) begin
            apply(tbl[k].i);
            @(negedge clk);
            chk($sformatf("t%0d fetch_req", k), {31'd0, fetch_req},
                {31'd0, tbl[k].exp_fetch});
            chk($sformatf("t%0d link_we", k), {31'd0, link_we},
                {31'd0, tbl[k].exp_link});
            chk($sformatf("t%0d link_addr", k), link_addr, prev_pc + 32'd4);
            @(posedge clk);
            #1;
            chk($sformatf("t%0d pc", k), pc, tbl[k].exp_pc);
            chk($sformatf("t%0d retired", k), retired, tbl[k].exp_ret);
            chk($sformatf("t%0d align_err", k), {31'd0, align_err},
                {31'd0, tbl[k].exp_err});
            prev_pc = tbl[k].exp_pc;
        end

        do_reset();
        check_reset_state("reset2");

        for (int n = 0; n < 3000; n++) begin
            rx.ready  = ($urandom_range(0, 3) != 0);
            rx.stall  = ($urandom_range(0, 3) == 0);
            rx.pcsrc  = ($urandom_range(0, 2) == 0);
            rx.jump   = ($urandom_range(0, 4) == 0);
            rx.jal    = ($urandom_range(0, 3) == 0);
            rx.jumpr  = ($urandom_range(0, 5) == 0);
            rx.imm    = 16'($urandom);
            rx.target = 26'($urandom);
            rx.rs     = $urandom;
            if ($urandom_range(0, 3) != 0)
                rx.rs[1:0] = 2'b00;
            mstep(rx, $sformatf("r%0d", n));
        end

        // Reset mid-EXEC with jal pending: no link write, counters cleared.
        while (!m_exec)
            mstep(mk(1,0,0,0,0,0,16'h0,26'h0,32'h0), "sync");
        mid_reset(mk(1,0,0,0,1,0,16'h0,26'h0,32'h0), "rst_exec");
        mstep(mk(1,0,0,0,0,0,16'h0,26'h0,32'h0), "rx0");
        mstep(mk(1,0,0,0,0,0,16'h0,26'h0,32'h0), "rx1");
        chk("rx pc", pc, 32'h0040_0004);

        // PC wrap upward, then a negative branch below zero.
        mstep(mk(1,0,0,0,0,0,16'h0,26'h0,32'h0), "w0");
        mstep(mk(1,0,0,0,0,1,16'h0,26'h0,32'hFFFF_FFFC), "w1");
        mstep(mk(1,0,0,0,0,0,16'h0,26'h0,32'h0), "w2");
        mstep(mk(1,0,0,0,1,0,16'h0,26'h0,32'h0), "w3");
        chk("wrap pc", pc, 32'h0000_0000);
        mstep(mk(1,0,0,0,0,0,16'h0,26'h0,32'h0), "w4");
        mstep(mk(1,0,1,0,0,0,16'hFFFE,26'h0,32'h0), "w5");
        chk("neg wrap pc", pc, 32'hFFFF_FFFC);

        // Reset mid-FETCH.
        mid_reset(mk(0,0,0,0,1,0,16'h0,26'h0,32'h0), "rst_fetch");
        mstep(mk(1,0,0,0,0,0,16'h0,26'h0,32'h0), "fx0");
        mstep(mk(1,0,0,0,0,0,16'h0,26'h0,32'h0), "fx1");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
